// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, start bit, 8 data + odd parity + stop, device ack check.
// Latency: ~INHIBIT_US + 11 device clocks per byte; backpressure: tx_ready low (tx_valid ignored) outside IDLE.
module ps2_host_tx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int INHIBIT_US   = 120,
    parameter int START_TMO_US = 15000,
    parameter int BIT_TMO_US   = 2000,
    parameter int FILT_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok
);
    localparam int unsigned INH_CYC   = 32'((64'(INHIBIT_US)   * 64'(CLK_HZ)) / 64'd1_000_000);
    localparam int unsigned START_CYC = 32'((64'(START_TMO_US) * 64'(CLK_HZ)) / 64'd1_000_000);
    localparam int unsigned BIT_CYC   = 32'((64'(BIT_TMO_US)   * 64'(CLK_HZ)) / 64'd1_000_000);
    localparam int unsigned TMR_MAX   = (INH_CYC > START_CYC) ? ((INH_CYC > BIT_CYC) ? INH_CYC : BIT_CYC)
                                                              : ((START_CYC > BIT_CYC) ? START_CYC : BIT_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int FC_W  = $clog2(FILT_LEN + 1);

    localparam logic [TMR_W-1:0] INH_LOAD   = TMR_W'(INH_CYC - 1);
    localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] BIT_LOAD   = TMR_W'(BIT_CYC - 1);
    localparam logic [FC_W-1:0]  FILT_LAST  = FC_W'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_FIRST, S_XFER, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic              data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic              clk_filt_q, clk_filt_d;
    logic [FC_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        byte_q, byte_d;
    logic              par_q, par_d;
    logic [3:0]        bit_q, bit_d;
    logic              ack_q, ack_d;
    logic              clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic              busy_q, busy_d, ready_q, ready_d;
    logic              done_q, done_d, ack_ok_q, ack_ok_d;
    logic              fe, tmr_expired, to_fail;

    always_comb begin
        clk_s1_d   = ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        data_s1_d  = ps2_data_in;
        data_s2_d  = data_s1_q;
        clk_filt_d = clk_filt_q;
        filt_cnt_d = filt_cnt_q;
        fe         = 1'b0;

        // New clock level accepted only after FILT_LEN consecutive differing samples.
        if (clk_s2_q == clk_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            clk_filt_d = clk_s2_q;
            filt_cnt_d = '0;
            fe         = clk_filt_q;
        end else begin
            filt_cnt_d = filt_cnt_q + FC_W'(1);
        end

        state_d     = state_q;
        byte_d      = byte_q;
        par_d       = par_q;
        bit_d       = bit_q;
        ack_d       = ack_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        ack_ok_d    = 1'b0;
        to_fail     = 1'b0;
        tmr_expired = (tmr_q == '0);
        tmr_d       = tmr_expired ? tmr_q : tmr_q - TMR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    byte_d   = tx_data;
                    par_d    = ~^tx_data;
                    ack_d    = 1'b0;
                    bit_d    = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmr_expired) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                state_d  = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                if (fe) begin
                    data_oe_d = ~byte_q[0];
                    bit_d     = 4'd1;
                    state_d   = S_XFER;
                end else if (tmr_expired) begin
                    to_fail = 1'b1;
                end
            end
            S_XFER: begin
                if (fe) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q <= 4'd7) begin
                        data_oe_d = ~byte_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (tmr_expired) begin
                    to_fail = 1'b1;
                end
            end
            S_ACK: begin
                if (fe) begin
                    if (!data_s2_q) begin
                        ack_d   = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        to_fail = 1'b1;
                    end
                end else if (tmr_expired) begin
                    to_fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && data_s2_q) begin
                    done_d   = 1'b1;
                    ack_ok_d = ack_q;
                    state_d  = S_DONE;
                end else if (tmr_expired) begin
                    to_fail = 1'b1;
                end
            end
            S_DONE, S_FAIL: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                state_d   = S_IDLE;
            end
        endcase

        if (to_fail) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_ok_d  = 1'b0;
            state_d   = S_FAIL;
        end

        // Only bit-phase states restart on fe; the inhibit's own clock pull-down must not stretch it.
        if ((state_d != state_q) || (fe && (state_q inside {S_XFER, S_ACK, S_WAIT_IDLE}))) begin
            case (state_d)
                S_INHIBIT:                   tmr_d = INH_LOAD;
                S_WAIT_FIRST:                tmr_d = START_LOAD;
                S_XFER, S_ACK, S_WAIT_IDLE:  tmr_d = BIT_LOAD;
                default:                     tmr_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            tmr_q      <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            bit_q      <= '0;
            ack_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            tmr_q      <= tmr_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            bit_q      <= bit_d;
            ack_q      <= ack_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outgoing half of the keyboard link whose incoming half is the existing PS2_keyboard receiver.
- Sends single command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables, and reports acknowledge or failure to the game logic.
- While busy it flags the receiver path so that path can ignore line activity caused by its own transmission.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- INHIBIT_US, 120, time the host holds ps2_clk low before the start bit.
- START_TMO_US, 15000, maximum wait from clock release to the first device falling edge.
- BIT_TMO_US, 2000, maximum wait between consecutive device falling edges. Also bounds the final wait for both lines to go idle.
- FILT_LEN, 4, number of consecutive equal synchronized samples required to accept a new ps2_clk level.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request to send. Accepted in the cycle where tx_valid=1 and tx_ready=1.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  sampled PS/2 clock line.
- ps2_data_in  in  1  sampled PS/2 data line.
- ps2_clk_oe  out  1  1 = pull the PS/2 clock line low, 0 = release it.
- ps2_data_oe  out  1  1 = pull the PS/2 data line low, 0 = release it.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer ends.
- ack_ok  out  1  valid while done=1. 1 = device acknowledged, 0 = error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ps2_clk_oe=0, ps2_data_oe=0; done=0, ack_ok=0, busy=0, tx_ready=1; all counters cleared.
- Line conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - The clock then passes a FILT_LEN glitch filter.
  - A "falling edge" is a filtered 1->0 transition, giving a single-cycle fe pulse.
  - Data is read from the synchronized value in the same cycle as fe.
- Parity: odd parity, par = ~^tx_data, computed from the byte latched at acceptance.
- Timers: the cycle counter is reloaded on every state entry and on every fe.
- States:
  - IDLE: tx_ready=1, outputs released. On accept: latch the byte, compute parity, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0, for INHIBIT_US*CLK_HZ/1e6 cycles (12000 at default). Then go to REQ.
  - REQ: exactly one cycle with clk_oe=1 and data_oe=1 (start bit). Then go to WAIT_FIRST.
  - WAIT_FIRST: clk_oe=0, data_oe=1.
    - On fe: data_oe=~tx_data[0], bit_idx=1, go to XFER.
    - If START_TMO expires: go to FAIL.
  - XFER: the host changes data only on fe.
    - On fe with bit_idx 1..7: data_oe=~tx_data[bit_idx].
    - On fe with bit_idx 8: data_oe=~par.
    - On fe with bit_idx 9: data_oe=0 (stop bit released), go to ACK.
    - bit_idx increments on each fe.
    - If BIT_TMO expires: go to FAIL.
  - ACK: outputs released.
    - On fe: sample data. If data=0, set the ack flag. If data=1, go to FAIL.
    - If BIT_TMO expires: go to FAIL.
    - After a valid ack, go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines have been high for one cycle, then go to DONE. If BIT_TMO expires first, go to FAIL.
  - DONE: done=1, ack_ok=1 for one cycle, then go to IDLE.
  - FAIL: both enables released immediately; done=1, ack_ok=0 for one cycle, then go to IDLE.
- tx_valid while busy is ignored, not queued. tx_data is sampled only at acceptance.
- Device-initiated traffic while in IDLE is not touched. The PS2_keyboard receiver handles it.
- The host never drives either line high. The enables are the only line outputs.
- rst asserted mid-transfer: both lines are released within the same cycle (asynchronous). The device recovers on its own by timeout.
- done is never asserted together with tx_ready in the same cycle.

Test Plan:
- Send 0xED with a device model that generates 11 clocks (40us period) and pulls data low on clock 11:
  - Host data bits on successive fe, as line levels: 1,0,1,1,0,1,1,1; parity 1; stop released.
  - Response: done=1, ack_ok=1; tx_ready returns high 1 cycle later.
- Send 0xF4: wire bits LSB first 0,0,1,0,1,1,1,1; parity 0. Send 0x00: parity 1. Check done with ack_ok=1 for both.
- Inhibit timing: after acceptance, ps2_clk_oe stays 1 for exactly 12000 cycles, then data_oe=1 with clk_oe=1 for 1 cycle.
- Device never clocks: after 15ms, FAIL with done=1, ack_ok=0, and both enables at 0.
- Device leaves data high on clock 11 (NACK): done=1, ack_ok=0.
- Stall after 5 clocks: BIT_TMO leads to FAIL. A 2-cycle glitch on ps2_clk must not advance bit_idx.
- Assert rst during XFER bit 4: both enables are 0 in the same cycle, state=IDLE, and a subsequent 0xFF transfer completes with ack_ok=1.
- tx_valid pulsed while busy: no second transfer starts and exactly one done pulse is produced.
